// File: rtl/craps_pkg.sv
// craps_pkg: shared state encoding, sum width, dice limits and roll-outcome constants
package craps_pkg;
  localparam int SUM_W = 4;
  typedef enum logic [1:0] {COME_OUT = 2'b00, POINT = 2'b01, WIN = 2'b10, LOSE = 2'b11} state_t;
  localparam logic [SUM_W-1:0] NATURAL_7 = 4'd7;
  localparam logic [SUM_W-1:0] YO_11 = 4'd11;
  localparam logic [SUM_W-1:0] CRAPS_2 = 4'd2;
  localparam logic [SUM_W-1:0] CRAPS_3 = 4'd3;
  localparam logic [SUM_W-1:0] CRAPS_12 = 4'd12;
  localparam logic [2:0] DIE_MIN = 3'd1;
  localparam logic [2:0] DIE_MAX = 3'd6;
  function automatic logic die_ok(input logic [2:0] d);
    return d >= DIE_MIN && d <= DIE_MAX;
  endfunction
endpackage

// File: rtl/craps_ctrl_sat_counter.sv
// sat_counter: clearable up-counter that sticks at all-ones
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  // clear wins over increment; increment stops at all-ones
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= '0;
    else if (clr) q <= '0;
    else if (inc && !(&q)) q <= q + 1'b1;
endmodule

// File: rtl/craps_ctrl.sv
// craps_ctrl: roll edge detect, dice capture and craps game FSM with saturating tallies
module craps_ctrl
  import craps_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       dice1_in,
  input  logic [2:0]       dice2_in,
  input  logic             roll,
  input  logic             new_game,
  output logic [SUM_W-1:0] sum,
  output logic [SUM_W-1:0] point,
  output logic [1:0]       state,
  output logic             win,
  output logic             lose,
  output logic             dice_err,
  output logic [CNT_W-1:0] roll_cnt,
  output logic [CNT_W-1:0] win_cnt,
  output logic [CNT_W-1:0] loss_cnt
);
  state_t st, rolled, nxt;
  logic roll_q, roll_evt, take, acc, err;
  logic [SUM_W-1:0] s;
  assign s = SUM_W'(dice1_in) + SUM_W'(dice2_in);
  assign roll_evt = roll & ~roll_q;
  assign take = roll_evt & ~new_game & (st == COME_OUT || st == POINT);
  assign acc = take & die_ok(dice1_in) & die_ok(dice2_in);
  assign err = take & ~acc;
  assign state = st;
  // outcome of an accepted roll, then new_game priority over the roll
  always_comb begin
    rolled = st == COME_OUT
      ? ((s == NATURAL_7 || s == YO_11) ? WIN : (s == CRAPS_2 || s == CRAPS_3 || s == CRAPS_12) ? LOSE : POINT)
      : (s == point ? WIN : s == NATURAL_7 ? LOSE : POINT);
    nxt = new_game ? COME_OUT : acc ? rolled : st;
  end
  // game FSM with registered win/lose decode, sum/point capture and error pulse
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st <= COME_OUT;
      roll_q <= 1'b0;
      sum <= '0;
      point <= '0;
      dice_err <= 1'b0;
      win <= 1'b0;
      lose <= 1'b0;
    end else begin
      roll_q <= roll;
      st <= nxt;
      win <= nxt == WIN;
      lose <= nxt == LOSE;
      dice_err <= err;
      if (new_game) begin
        sum <= '0;
        point <= '0;
      end else if (acc) begin
        sum <= s;
        if (st == COME_OUT && rolled == POINT) point <= s;
      end
    end
  sat_counter #(.W(CNT_W)) u_roll_cnt (.clk(clk), .rst(rst), .clr(new_game), .inc(acc), .q(roll_cnt));
  sat_counter #(.W(CNT_W)) u_win_cnt (.clk(clk), .rst(rst), .clr(1'b0), .inc(acc && rolled == WIN), .q(win_cnt));
  sat_counter #(.W(CNT_W)) u_loss_cnt (.clk(clk), .rst(rst), .clr(1'b0), .inc(acc && rolled == LOSE), .q(loss_cnt));
endmodule

// File: tb/tb_craps_ctrl.sv
// tb_craps_ctrl: directed scenario tasks for craps_ctrl, plus a 2-bit tally instance for saturation
module tb_craps_ctrl;
  logic clk = 1'b0, rst = 1'b0, rst2 = 1'b0, roll = 1'b0, new_game = 1'b0;
  logic [2:0] dice1_in = 3'd1, dice2_in = 3'd1;
  logic [3:0] sum, point, sum2, point2;
  logic [1:0] state, state2;
  logic win, lose, dice_err, win2, lose2, dice_err2;
  logic [7:0] roll_cnt, win_cnt, loss_cnt;
  logic [1:0] roll_cnt2, win_cnt2, loss_cnt2;
  int errors = 0, checks = 0;

  craps_ctrl #(.CNT_W(8)) dut (.clk(clk), .rst(rst), .dice1_in(dice1_in), .dice2_in(dice2_in),
    .roll(roll), .new_game(new_game), .sum(sum), .point(point), .state(state), .win(win),
    .lose(lose), .dice_err(dice_err), .roll_cnt(roll_cnt), .win_cnt(win_cnt), .loss_cnt(loss_cnt));

  craps_ctrl #(.CNT_W(2)) dut2 (.clk(clk), .rst(rst2), .dice1_in(dice1_in), .dice2_in(dice2_in),
    .roll(roll), .new_game(new_game), .sum(sum2), .point(point2), .state(state2), .win(win2),
    .lose(lose2), .dice_err(dice_err2), .roll_cnt(roll_cnt2), .win_cnt(win_cnt2), .loss_cnt(loss_cnt2));

  always #5 clk = ~clk;

  task automatic do_roll(input logic [2:0] a, input logic [2:0] b);
    @(negedge clk);
    dice1_in = a;
    dice2_in = b;
    roll = 1'b1;
    @(negedge clk);
    roll = 1'b0;
  endtask

  task automatic do_new_game();
    @(negedge clk);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if ({state, sum, point} !== 10'd0) begin errors++; $display("FAIL reset_state_sum_point got=%h exp=0", {state, sum, point}); end
    checks++; if ({win, lose, dice_err} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {win, lose, dice_err}); end
    checks++; if ({roll_cnt, win_cnt, loss_cnt} !== 24'd0) begin errors++; $display("FAIL reset_counters got=%h exp=0", {roll_cnt, win_cnt, loss_cnt}); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_natural();
    do_roll(3'd3, 3'd4);
    checks++; if (sum !== 4'd7) begin errors++; $display("FAIL natural_sum got=%0d exp=7", sum); end
    checks++; if (state !== 2'b10 || win !== 1'b1 || lose !== 1'b0) begin errors++; $display("FAIL natural_state got=%b/%b%b exp=10/10", state, win, lose); end
    checks++; if (win_cnt !== 8'd1 || roll_cnt !== 8'd1) begin errors++; $display("FAIL natural_counts win_cnt=%0d roll_cnt=%0d exp=1,1", win_cnt, roll_cnt); end
  endtask

  task automatic test_craps();
    do_new_game();
    checks++; if (state !== 2'b00 || sum !== 4'd0 || roll_cnt !== 8'd0 || win_cnt !== 8'd1) begin errors++; $display("FAIL newgame_clear state=%b sum=%0d roll_cnt=%0d win_cnt=%0d exp=00,0,0,1", state, sum, roll_cnt, win_cnt); end
    do_roll(3'd1, 3'd1);
    checks++; if (state !== 2'b11 || lose !== 1'b1 || win !== 1'b0 || sum !== 4'd2) begin errors++; $display("FAIL craps_lose state=%b lose=%b win=%b sum=%0d exp=11,1,0,2", state, lose, win, sum); end
    checks++; if (loss_cnt !== 8'd1) begin errors++; $display("FAIL craps_loss_cnt got=%0d exp=1", loss_cnt); end
    do_roll(3'd5, 3'd6);
    checks++; if (state !== 2'b11 || sum !== 4'd2 || roll_cnt !== 8'd1 || loss_cnt !== 8'd1 || dice_err !== 1'b0) begin errors++; $display("FAIL lose_ignores_roll state=%b sum=%0d roll_cnt=%0d loss_cnt=%0d err=%b exp=11,2,1,1,0", state, sum, roll_cnt, loss_cnt, dice_err); end
  endtask

  task automatic test_point_win();
    do_new_game();
    do_roll(3'd2, 3'd2);
    checks++; if (state !== 2'b01 || point !== 4'd4 || sum !== 4'd4) begin errors++; $display("FAIL point_set state=%b point=%0d sum=%0d exp=01,4,4", state, point, sum); end
    do_roll(3'd3, 3'd5);
    checks++; if (state !== 2'b01 || sum !== 4'd8 || roll_cnt !== 8'd2 || point !== 4'd4) begin errors++; $display("FAIL point_stay state=%b sum=%0d roll_cnt=%0d point=%0d exp=01,8,2,4", state, sum, roll_cnt, point); end
    do_roll(3'd1, 3'd3);
    checks++; if (state !== 2'b10 || win !== 1'b1 || win_cnt !== 8'd2 || roll_cnt !== 8'd3) begin errors++; $display("FAIL point_win state=%b win=%b win_cnt=%0d roll_cnt=%0d exp=10,1,2,3", state, win, win_cnt, roll_cnt); end
  endtask

  task automatic test_point_lose();
    do_new_game();
    do_roll(3'd3, 3'd3);
    do_roll(3'd2, 3'd5);
    checks++; if (state !== 2'b11 || point !== 4'd6 || sum !== 4'd7 || lose !== 1'b1) begin errors++; $display("FAIL seven_out state=%b point=%0d sum=%0d lose=%b exp=11,6,7,1", state, point, sum, lose); end
    checks++; if (loss_cnt !== 8'd2 || win_cnt !== 8'd2) begin errors++; $display("FAIL seven_out_tally loss=%0d win=%0d exp=2,2", loss_cnt, win_cnt); end
  endtask

  task automatic test_dice_err();
    do_new_game();
    do_roll(3'd0, 3'd4);
    checks++; if (dice_err !== 1'b1 || state !== 2'b00 || sum !== 4'd0 || roll_cnt !== 8'd0) begin errors++; $display("FAIL err_die0 err=%b state=%b sum=%0d roll_cnt=%0d exp=1,00,0,0", dice_err, state, sum, roll_cnt); end
    @(negedge clk);
    checks++; if (dice_err !== 1'b0) begin errors++; $display("FAIL err_one_cycle got=%b exp=0", dice_err); end
    do_roll(3'd7, 3'd2);
    checks++; if (dice_err !== 1'b1 || roll_cnt !== 8'd0) begin errors++; $display("FAIL err_die7 err=%b roll_cnt=%0d exp=1,0", dice_err, roll_cnt); end
    do_roll(3'd3, 3'd3);
    do_roll(3'd2, 3'd7);
    checks++; if (dice_err !== 1'b1 || state !== 2'b01 || sum !== 4'd6 || roll_cnt !== 8'd1) begin errors++; $display("FAIL err_in_point err=%b state=%b sum=%0d roll_cnt=%0d exp=1,01,6,1", dice_err, state, sum, roll_cnt); end
  endtask

  task automatic test_roll_hold();
    @(negedge clk);
    dice1_in = 3'd4;
    dice2_in = 3'd4;
    roll = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (roll_cnt !== 8'd2 || sum !== 4'd8 || state !== 2'b01) begin errors++; $display("FAIL roll_hold roll_cnt=%0d sum=%0d state=%b exp=2,8,01", roll_cnt, sum, state); end
    roll = 1'b0;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    dice1_in = 3'd3;
    dice2_in = 3'd3;
    roll = 1'b1;
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    checks++; if (state !== 2'b00 || roll_cnt !== 8'd0 || point !== 4'd0 || sum !== 4'd0 || win_cnt !== 8'd2) begin errors++; $display("FAIL newgame_priority state=%b roll_cnt=%0d point=%0d sum=%0d win_cnt=%0d exp=00,0,0,0,2", state, roll_cnt, point, sum, win_cnt); end
    @(negedge clk);
    checks++; if (state !== 2'b00 || roll_cnt !== 8'd0) begin errors++; $display("FAIL held_roll_no_retrigger state=%b roll_cnt=%0d exp=00,0", state, roll_cnt); end
    roll = 1'b0;
  endtask

  task automatic test_async_reset();
    do_new_game();
    do_roll(3'd2, 3'd2);
    #2 rst = 1'b0;
    #1;
    checks++; if ({state, sum, point, win, lose, dice_err} !== 13'd0) begin errors++; $display("FAIL async_reset_state got=%h exp=0", {state, sum, point, win, lose, dice_err}); end
    checks++; if ({roll_cnt, win_cnt, loss_cnt} !== 24'd0) begin errors++; $display("FAIL async_reset_counters got=%h exp=0", {roll_cnt, win_cnt, loss_cnt}); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_saturate();
    logic [1:0] exp2;
    @(negedge clk);
    rst2 = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      do_roll(3'd5, 3'd6);
      exp2 = i >= 3 ? 2'd3 : 2'(i);
      checks++; if (win_cnt2 !== exp2) begin errors++; $display("FAIL sat_win_cnt game=%0d got=%0d exp=%0d", i, win_cnt2, exp2); end
      do_new_game();
    end
    checks++; if (win_cnt !== 8'd5) begin errors++; $display("FAIL wide_win_cnt got=%0d exp=5", win_cnt); end
  endtask

  initial begin
    test_reset();
    test_natural();
    test_craps();
    test_point_win();
    test_point_lose();
    test_dice_err();
    test_roll_hold();
    test_back_to_back();
    test_async_reset();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
